// File: rtl/rme_pkg.sv
// Shared sizing and types for the row-major extract path (column extractor and row packer).
package rme_pkg;

    localparam int BUS_BYTES = 16;
    localparam int COL_BYTES = 64;
    localparam int ACC_BYTES = COL_BYTES + BUS_BYTES;

    typedef logic [8*BUS_BYTES-1:0] beat_t;
    typedef logic [8*COL_BYTES-1:0] col_t;
    typedef logic [6:0]             bytecnt_t;

    // Field widths above the column maximum are treated as a full-width column.
    function automatic bytecnt_t clamp_width(input bytecnt_t width, input bytecnt_t max_width);
        return (width > max_width) ? max_width : width;
    endfunction

endpackage

// File: rtl/byte_mask_gen.sv
// Combinational byte-count to MSB-first byte-enable mask: mask[N-1] is byte 0.
module byte_mask_gen
    import rme_pkg::*;
#(
    parameter int N = 16
) (
    input  bytecnt_t       count,
    output logic [N-1:0]   mask
);

    always_comb begin
        mask = '0;
        for (int i = 0; i < N; i++) begin
            mask[N-1-i] = (i < int'(count));
        end
    end

endmodule

// File: rtl/row_packer.sv
// Packs left-aligned column fields byte-contiguously into BUS_BYTES-wide beats and
// flushes a partial beat at row end. valid/ready: a beat transfers on any edge where o_valid && i_ready.
module row_packer
    import rme_pkg::*;
#(
    parameter int BUS_BYTES = rme_pkg::BUS_BYTES,
    parameter int COL_BYTES = rme_pkg::COL_BYTES,
    parameter int ACC_BYTES = rme_pkg::ACC_BYTES
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic [8*COL_BYTES-1:0] i_col_data,
    input  bytecnt_t               i_width,
    input  logic                   i_row_last,
    output logic                   o_ready,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [8*BUS_BYTES-1:0] o_data,
    output logic [BUS_BYTES-1:0]   o_keep,
    output logic                   o_last
);

    localparam int       BUS_W   = 8 * BUS_BYTES;
    localparam int       COL_W   = 8 * COL_BYTES;
    localparam int       ACC_W   = 8 * ACC_BYTES;
    localparam bytecnt_t BUS_CNT = bytecnt_t'(BUS_BYTES);
    localparam bytecnt_t COL_CNT = bytecnt_t'(COL_BYTES);

    logic [ACC_W-1:0] r_acc;
    bytecnt_t         r_fill;
    logic             r_flush;

    logic             full_beat;
    logic             accept;
    logic             emit;
    bytecnt_t         width_c;
    logic [COL_BYTES-1:0] col_byte_mask;
    logic [COL_W-1:0] col_bit_mask;
    logic [BUS_BYTES-1:0] keep_mask;
    logic [ACC_W-1:0] post_acc;
    bytecnt_t         post_fill;
    logic [ACC_W-1:0] field_ext;
    logic [ACC_W-1:0] placed;
    logic [9:0]       place_shift;

    // Output decode: registers only, forced quiet while reset is held.
    assign full_beat = (r_fill >= BUS_CNT);
    assign o_ready   = !i_rst && !r_flush && (r_fill <= BUS_CNT);
    assign o_valid   = !i_rst && (full_beat || r_flush);
    assign o_last    = !i_rst && r_flush && (r_fill <= BUS_CNT);
    assign o_data    = i_rst ? '0 : r_acc[ACC_W-1 -: BUS_W];
    assign o_keep    = i_rst ? '0 : (full_beat ? '1 : keep_mask);

    assign accept  = i_en && o_ready;
    assign emit    = o_valid && i_ready;
    assign width_c = clamp_width(i_width, COL_CNT);

    byte_mask_gen #(.N(BUS_BYTES)) u_keep_mask (
        .count (r_fill),
        .mask  (keep_mask)
    );

    byte_mask_gen #(.N(COL_BYTES)) u_col_mask (
        .count (width_c),
        .mask  (col_byte_mask)
    );

    always_comb begin
        col_bit_mask = '0;
        for (int b = 0; b < COL_BYTES; b++) begin
            col_bit_mask[8*b +: 8] = {8{col_byte_mask[b]}};
        end
    end

    // Emit is applied before placement, so a same-cycle accept lands at the post-emit fill.
    always_comb begin
        post_acc  = emit ? (r_acc << BUS_W) : r_acc;
        post_fill = r_fill;
        if (emit) begin
            post_fill = full_beat ? (r_fill - BUS_CNT) : '0;
        end
        field_ext                    = '0;
        field_ext[ACC_W-1 -: COL_W]  = i_col_data & col_bit_mask;
        place_shift                  = {post_fill, 3'b000};
        placed                       = field_ext >> place_shift;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc   <= '0;
            r_fill  <= '0;
            r_flush <= 1'b0;
        end else begin
            if (emit && o_last) begin
                r_flush <= 1'b0;
            end
            if (accept) begin
                r_acc  <= post_acc | placed;
                r_fill <= post_fill + width_c;
                if (i_row_last) begin
                    r_flush <= 1'b1;
                end
            end else if (emit) begin
                r_acc  <= post_acc;
                r_fill <= post_fill;
            end
        end
    end

endmodule

// File: doc/row_packer.md
# row_packer

Downstream neighbour of the column extractor. It takes extracted column values, each a left-aligned field of 1–64 bytes, and packs them byte-contiguously into a stream of 16-byte beats. A beat goes out whenever 16 bytes are available, and the row is flushed with a partial beat at row end. Its output stream feeds the projected-row cache write path.

## Interface
- `BUS_BYTES`, default 16: output beat width in bytes.
- `COL_BYTES`, default 64: maximum column field width in bytes.
- `ACC_BYTES`, default 80: accumulator depth in bytes, equal to `COL_BYTES` + `BUS_BYTES`.
- `i_clk` in, 1: the single clock; all logic is on the rising edge.
- `i_rst` in, 1: synchronous, active-high reset.
- `i_en` in, 1: column-valid pulse from the extractor.
- `i_col_data` in, 8·`COL_BYTES`: column field, MSB-aligned; byte 0 is bits [511:504].
- `i_width` in, 7: field width in bytes; legal range 0–64.
- `i_row_last` in, 1: the column is the last one of its row.
- `o_ready` out, 1: the block can accept a column this cycle.
- `o_valid` out, 1: an output beat is presented.
- `i_ready` in, 1: the consumer accepts the beat.
- `o_data` out, 8·`BUS_BYTES`: output beat, MSB-first; byte 0 is bits [127:120].
- `o_keep` out, `BUS_BYTES`: byte-valid mask; bit 15 corresponds to byte 0.
- `o_last` out, 1: final beat of the row.

## Operation
**State**
- `r_acc`: `ACC_BYTES`-byte accumulator, MSB-first.
- `r_fill`: 7-bit count of valid bytes, range 0–80.
- `r_flush`: row end is pending.

**Acceptance**
- A column is accepted when `i_en && o_ready`.
- `o_ready = !r_flush && r_fill <= 16`. This guarantees that a 64-byte field always fits.
- `i_en` while `o_ready` is 0 is dropped. The extractor spaces its pulses ≥2 cycles apart, and the stage above must respect `o_ready`.

**Placement on accept**
- Width `w = min(i_width, 64)`.
- Bytes of `i_col_data` at index ≥ `w` are zeroed.
- The masked field is written at accumulator byte offset `f`, where `f` is the post-emit fill for this cycle.
- New fill is `f + w`.
- If `i_row_last` is set, `r_flush` is set to 1.

**Emit**
- `o_valid = r_fill >= 16 || (r_flush && !i_rst)`.
- `o_data` is accumulator bytes 0–15.
- `o_keep`: all ones if `r_fill >= 16`, otherwise the top `r_fill` bits set.
- `o_last = r_flush && r_fill <= 16`.
- On `o_valid && i_ready`:
  - the accumulator shifts left 16 bytes, with zeros filling in;
  - `r_fill` becomes `max(r_fill − 16, 0)`;
  - if `o_last` is set, `r_flush` clears.

**Simultaneous accept and emit**
- Accept and emit in the same cycle is legal only when `r_fill == 16`.
- The emit is applied first (`f = 0`), then the field is placed at byte 0.

**Boundary cases**
- Width 0: the column contributes no bytes, but `i_row_last` still sets `r_flush`. If `r_fill` is 0 at flush, one beat is emitted with `o_keep = 0` and `o_last = 1`.
- Exactly 16·k bytes in a row: the final full beat carries `o_last = 1`; no empty beat follows.
- Width > 64: clamped to 64.
- `o_valid` holds, with `o_data`, `o_keep` and `o_last` stable, until `i_ready` is seen.

## Timing
- Reset values: accumulator 0, `r_fill` 0, `r_flush` 0.
- While `i_rst` is high: `o_valid` 0, `o_data` 0, `o_keep` 0, `o_last` 0, and `o_ready` forced to 0. `o_ready` is 1 in the first cycle after reset deasserts.
- Reset mid-row discards all accumulated bytes; no `o_last` is produced.
- A column accepted at edge t can make `o_valid` high in cycle t+1. Outputs are decoded from registers only; there is no combinational path from `i_en` or `i_col_data` to outputs.
- `o_ready` depends on registers only, never on `i_ready`.
- Throughput: one beat per cycle while `r_fill >= 16` and `i_ready` is high.
- Flush latency: `ceil(r_fill / 16)` beats after the last column is accepted.

## Structure
- Package `rme_pkg` holds `BUS_BYTES`, `COL_BYTES`, `ACC_BYTES`, and typedefs `beat_t` (128b), `col_t` (512b) and `bytecnt_t` (7b). The extractor shares these values.
- Sub-module `byte_mask_gen`: combinational; maps a byte count (0–64) to an MSB-first byte-enable mask. It is used for input field masking and for `o_keep`.
- One always block holds the accumulator, fill and flush state; output decode is combinational from those registers.

## Test plan
- **Single row of 4 and 8 bytes:** send widths 4, then 8 with `i_row_last`, `i_ready` = 1 → one beat with the 12 bytes in order, `o_keep = 16'hFFF0`, `o_last = 1`.
- **Full-width column:** one column of width 64 with `i_row_last` → 4 beats, each `o_keep = FFFF`, `o_last` on the 4th only; `o_ready` is 0 until the flush completes.
- **Straddling beats:** widths 10, 10, 12 with last on the third → beats of 16 bytes then 16 bytes, second beat `o_last = 1`, no third beat; byte order preserved across the straddle.
- **Backpressure:** hold `i_ready` = 0 for 5 cycles with fill at 20 → `o_valid` stays high, data stable, `o_ready` = 0; release → beats drain in order.
- **Zero width and clamp:** width 0 with last on an empty accumulator → one beat with `o_keep = 0`, `o_last = 1`. Width 100 → treated as 64.
- **Reset mid-row:** fill 40 and assert `i_rst` for 1 cycle → `o_valid` = 0 during reset, `o_ready` = 1 the next cycle, no stale bytes in the next row's first beat.
